// File: rtl/posit_unit_arbiter.sv
// Round-robin arbiter that shares one fixed-latency, fully pipelined posit
// unit among NUM_REQ requesters. It registers operands into the unit, uses a
// tag pipe to return each result with its owner ID, and supports a drain
// (flush) sequence.
module posit_unit_arbiter #(
    parameter int unsigned POSIT_WIDTH  = 16,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned UNIT_LATENCY = 4,
    parameter int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*POSIT_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*POSIT_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ-1:0]              req_op,
    input  logic                            flush_i,
    output logic                            unit_valid_o,
    output logic [POSIT_WIDTH-1:0]          unit_a_o,
    output logic [POSIT_WIDTH-1:0]          unit_b_o,
    output logic                            unit_op_o,
    input  logic [POSIT_WIDTH-1:0]          unit_res_i,
    output logic                            res_valid,
    output logic [ID_W-1:0]                 res_id,
    output logic [POSIT_WIDTH-1:0]          res_data,
    output logic                            busy,
    output logic                            flush_done
);

    localparam int unsigned CNT_W = $clog2(UNIT_LATENCY + 2);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        cand;
    logic                   grant;
    logic [UNIT_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [UNIT_LATENCY];
    logic [CNT_W-1:0]       count;
    logic [POSIT_WIDTH-1:0] a_arr [NUM_REQ];
    logic [POSIT_WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign a_arr[g] = req_a[g*POSIT_WIDTH +: POSIT_WIDTH];
        assign b_arr[g] = req_b[g*POSIT_WIDTH +: POSIT_WIDTH];
    end

    // Stage 0 of the tag pipe is loaded on the grant edge, so it is valid in
    // the same cycle as the issue strobe; the strobe is simply that stage.
    assign unit_valid_o = tag_v[0];
    assign busy         = (count != '0) || unit_valid_o;

    // Round-robin search from rr_ptr; flush and DRAIN suppress all grants.
    always_comb begin
        grant     = 1'b0;
        grant_id  = '0;
        cand      = '0;
        req_ready = '0;
        if (state == RUN && !flush_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
                if (!grant && req_valid[cand]) begin
                    grant    = 1'b1;
                    grant_id = cand;
                end
            end
            if (grant) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    // Next-state logic and drain-complete pulse.
    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                if (flush_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    flush_done = 1'b1;
                    state_next = flush_i ? DRAIN : RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Pointer advance and operand registers into the shared unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            unit_a_o  <= '0;
            unit_b_o  <= '0;
            unit_op_o <= 1'b0;
        end else if (grant) begin
            rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            unit_a_o  <= a_arr[grant_id];
            unit_b_o  <= b_arr[grant_id];
            unit_op_o <= req_op[grant_id];
        end
    end

    // Tag pipe tracking the owner of every in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < UNIT_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= grant;
            tag_id[0] <= grant_id;
            for (int unsigned i = 1; i < UNIT_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Result capture: unit output is sampled only when the tag says it is ours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_v[UNIT_LATENCY-1];
            if (tag_v[UNIT_LATENCY-1]) begin
                res_id   <= tag_id[UNIT_LATENCY-1];
                res_data <= unit_res_i;
            end
        end
    end

    // In-flight counter: issue increments, retire decrements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({unit_valid_o, res_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
